// File: rtl/polar_mem_pkg.sv
// Shared constants and layer-geometry helpers for the polar decoder memories.
package polar_mem_pkg;

    localparam int Q_DEF = 6;

    typedef logic [Q_DEF-1:0] llr_t;

    // Flat offset of layer l inside the alpha store: 2^l - 2.
    function automatic int layer_base(input int l);
        return (32'sd1 << l) - 32'sd2;
    endfunction

    // Number of p-lane chunks covering 2^l entries, never fewer than one.
    function automatic int layer_chunks(input int l, input int p);
        int c;
        c = (32'sd1 << l) / p;
        return (c < 32'sd1) ? 32'sd1 : c;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/alpha_chunk_tracker.sv
// Per-layer chunk-written bitmaps and the registered layer_rdy flags derived from them.
module alpha_chunk_tracker
    import polar_mem_pkg::*;
#(
    parameter int P = 128,
    parameter int N = 1024,
    localparam int LOG2N = $clog2(N),
    localparam int LOG2P = $clog2(P),
    localparam int LW    = $clog2(LOG2N + 1),
    localparam int AW    = LOG2N - LOG2P + 1,
    localparam int CMAX  = N / P
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [LW-1:0]    wr_layer,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LOG2N-1:0] layer_clr,
    output logic [LOG2N-1:0] layer_rdy
);

    logic [LOG2N-1:0][CMAX-1:0] map_r;
    logic [LOG2N-1:0][CMAX-1:0] map_next_s;
    logic [LOG2N-1:0]           rdy_r;
    logic [LOG2N-1:0]           rdy_next_s;

    // Clear is applied before the same-cycle write sets its chunk; chunks beyond a layer's size count as done.
    always_comb begin
        map_next_s = {(LOG2N*CMAX){1'b0}};
        rdy_next_s = {LOG2N{1'b0}};
        for (int li = 0; li < LOG2N; li++) begin
            rdy_next_s[li] = 1'b1;
            for (int j = 0; j < CMAX; j++) begin
                map_next_s[li][j] = (map_r[li][j] && !layer_clr[li]) ||
                                    (wr_en && (wr_layer == LW'(li + 32'sd1)) && (wr_addr == AW'(j)));
                rdy_next_s[li] = rdy_next_s[li] &
                                 (map_next_s[li][j] | (j >= layer_chunks(li + 32'sd1, P)));
            end
        end
    end

    // Bitmap and ready registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            map_r <= {(LOG2N*CMAX){1'b0}};
            rdy_r <= {LOG2N{1'b0}};
        end else begin
            map_r <= map_next_s;
            rdy_r <= rdy_next_s;
        end
    end

    assign layer_rdy = rdy_r;

endmodule

// File: rtl/alpha_layer_mem.sv
// Layer-wise alpha (LLR) store for the SCAN polar decoder: chunked P-lane writes and
// registered half-layer reads. Macro ALPHA_MEM_BYPASS_EN enables same-cycle write-to-read forwarding.
module alpha_layer_mem
    import polar_mem_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int P = 128,
    parameter int N = 1024,
    localparam int LOG2N = $clog2(N),
    localparam int LOG2P = $clog2(P),
    localparam int LW    = $clog2(LOG2N + 1),
    localparam int AW    = LOG2N - LOG2P + 1,
    localparam int CMAX  = N / P
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [LW-1:0]    wr_layer,
    input  logic [AW-1:0]    wr_addr,
    input  logic [P*Q-1:0]   wr_data,
    input  logic             rd_valid,
    input  logic [LW-1:0]    rd_layer,
    input  logic [AW-1:0]    rd_addr,
    input  logic [LOG2N-1:0] layer_clr,
    output logic [P*Q-1:0]   rd_left,
    output logic [P*Q-1:0]   rd_right,
    output logic             rd_data_valid,
    output logic             wr_err,
    output logic             rd_err,
    output logic [LOG2N-1:0] layer_rdy
);

    localparam int DEPTH = 2 * N - 2;
    localparam int IW    = $clog2(2 * N);

    logic [Q-1:0]   mem_r [DEPTH];
    logic           wr_ok_s;
    logic [IW-1:0]  wr_start_s;
    logic [IW-1:0]  wr_lanes_s;
    logic           rd_ok_s;
    logic [IW-1:0]  rd_lstart_s;
    logic [IW-1:0]  rd_rstart_s;
    logic [IW-1:0]  rd_lanes_s;
    logic [P*Q-1:0] left_next_s;
    logic [P*Q-1:0] right_next_s;
    logic [P*Q-1:0] rd_left_r;
    logic [P*Q-1:0] rd_right_r;
    logic           rd_dv_r;
    logic           rd_err_r;
    logic           wr_err_r;

`ifdef ALPHA_MEM_BYPASS_EN
    // A read lane whose entry falls inside the chunk being written takes the new lane value.
    function automatic logic [Q-1:0] fwd_lane(input logic [IW-1:0] e, input logic [Q-1:0] old_v,
                                              input logic wok, input logic [IW-1:0] ws,
                                              input logic [IW-1:0] wn, input logic [P*Q-1:0] wd);
        logic [IW-1:0] off;
        off = e - ws;
        if (wok && (e >= ws) && (off < wn)) begin
            return wd[int'(off)*Q +: Q];
        end else begin
            return old_v;
        end
    endfunction
`endif

    // Write range check and chunk geometry.
    always_comb begin
        wr_ok_s    = 1'b0;
        wr_start_s = {IW{1'b0}};
        wr_lanes_s = {IW{1'b0}};
        if (wr_valid && (int'(wr_layer) >= 32'sd1) && (int'(wr_layer) <= LOG2N) &&
            (int'(wr_addr) < layer_chunks(int'(wr_layer), P))) begin
            wr_ok_s    = 1'b1;
            wr_start_s = IW'(layer_base(int'(wr_layer)) + int'(wr_addr) * P);
            wr_lanes_s = IW'(min_int(32'sd1 << int'(wr_layer), P));
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Read range check; the right half sits H = 2^(l-1) entries above the left half.
    always_comb begin
        rd_ok_s     = 1'b0;
        rd_lstart_s = {IW{1'b0}};
        rd_rstart_s = {IW{1'b0}};
        rd_lanes_s  = {IW{1'b0}};
        if (rd_valid && (int'(rd_layer) >= 32'sd1) && (int'(rd_layer) <= LOG2N) &&
            (int'(rd_addr) < layer_chunks(int'(rd_layer) - 32'sd1, P))) begin
            rd_ok_s     = 1'b1;
            rd_lstart_s = IW'(layer_base(int'(rd_layer)) + int'(rd_addr) * P);
            rd_rstart_s = IW'(layer_base(int'(rd_layer)) + (32'sd1 << (int'(rd_layer) - 32'sd1)) +
                              int'(rd_addr) * P);
            rd_lanes_s  = IW'(min_int(32'sd1 << (int'(rd_layer) - 32'sd1), P));
        end else begin
            rd_ok_s = 1'b0;
        end
    end

    // Lane gather; lanes past the half-layer width stay zero.
    always_comb begin
        left_next_s  = {(P*Q){1'b0}};
        right_next_s = {(P*Q){1'b0}};
        for (int i = 0; i < P; i++) begin
            if (rd_ok_s && (IW'(i) < rd_lanes_s)) begin
`ifdef ALPHA_MEM_BYPASS_EN
                left_next_s[i*Q +: Q]  = fwd_lane(rd_lstart_s + IW'(i), mem_r[rd_lstart_s + IW'(i)],
                                                  wr_ok_s, wr_start_s, wr_lanes_s, wr_data);
                right_next_s[i*Q +: Q] = fwd_lane(rd_rstart_s + IW'(i), mem_r[rd_rstart_s + IW'(i)],
                                                  wr_ok_s, wr_start_s, wr_lanes_s, wr_data);
`else
                left_next_s[i*Q +: Q]  = mem_r[rd_lstart_s + IW'(i)];
                right_next_s[i*Q +: Q] = mem_r[rd_rstart_s + IW'(i)];
`endif
            end else begin
                left_next_s[i*Q +: Q]  = {Q{1'b0}};
                right_next_s[i*Q +: Q] = {Q{1'b0}};
            end
        end
    end

    // Chunk store; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            for (int i = 0; i < P; i++) begin
                if (IW'(i) < wr_lanes_s) begin
                    mem_r[wr_start_s + IW'(i)] <= wr_data[i*Q +: Q];
                end
            end
        end
    end

    // Registered read data and error strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_left_r  <= {(P*Q){1'b0}};
            rd_right_r <= {(P*Q){1'b0}};
            rd_dv_r    <= 1'b0;
            rd_err_r   <= 1'b0;
            wr_err_r   <= 1'b0;
        end else begin
            rd_left_r  <= left_next_s;
            rd_right_r <= right_next_s;
            rd_dv_r    <= rd_ok_s;
            rd_err_r   <= rd_valid && !rd_ok_s;
            wr_err_r   <= wr_valid && !wr_ok_s;
        end
    end

    alpha_chunk_tracker #(
        .P(P),
        .N(N)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_ok_s),
        .wr_layer  (wr_layer),
        .wr_addr   (wr_addr),
        .layer_clr (layer_clr),
        .layer_rdy (layer_rdy)
    );

    assign rd_left       = rd_left_r;
    assign rd_right      = rd_right_r;
    assign rd_data_valid = rd_dv_r;
    assign wr_err        = wr_err_r;
    assign rd_err        = rd_err_r;

endmodule

// File: tb/tb_alpha_layer_mem.sv
// Randomised self-checking bench for alpha_layer_mem against a behavioural layer-store model.
module tb_alpha_layer_mem;

    localparam int Q     = 6;
    localparam int P     = 128;
    localparam int N     = 1024;
    localparam int LOG2N = 10;
    localparam int LW    = 4;
    localparam int AW    = 4;
    localparam int CMAX  = N / P;
    localparam int DW    = P * Q;
`ifdef ALPHA_MEM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             wr_valid;
    logic [LW-1:0]    wr_layer;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rd_valid;
    logic [LW-1:0]    rd_layer;
    logic [AW-1:0]    rd_addr;
    logic [LOG2N-1:0] layer_clr;
    logic [DW-1:0]    rd_left;
    logic [DW-1:0]    rd_right;
    logic             rd_data_valid;
    logic             wr_err;
    logic             rd_err;
    logic [LOG2N-1:0] layer_rdy;

    int n_checks;
    int n_errors;

    int              ref_mem [2*N];
    bit [CMAX-1:0]   ref_done [LOG2N+1];

    alpha_layer_mem #(.Q(Q), .P(P), .N(N)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_layer(wr_layer), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_layer(rd_layer), .rd_addr(rd_addr), .layer_clr(layer_clr),
        .rd_left(rd_left), .rd_right(rd_right), .rd_data_valid(rd_data_valid),
        .wr_err(wr_err), .rd_err(rd_err), .layer_rdy(layer_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Chunks of 2^l entries in P-lane accesses (at least one).
    function automatic int n_chunks(input int entries);
        if (entries <= P) return 1;
        return entries / P;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock: drive inputs, predict the registered outputs, compare after the edge, update the model.
    task automatic run_cycle(input bit wv, input int wl, input int wk, input logic [DW-1:0] wd,
                             input bit rv, input int rl, input int rk,
                             input logic [LOG2N-1:0] clr, input bit rs);
        bit               wlegal, rlegal;
        int               ws, wn, h, rn, lb, e;
        logic [DW-1:0]    exp_l, exp_r;
        logic [LOG2N-1:0] exp_rdy;
        bit               exp_dv, exp_re, exp_we, all_done;

        rst = rs; wr_valid = wv; wr_layer = LW'(wl); wr_addr = AW'(wk); wr_data = wd;
        rd_valid = rv; rd_layer = LW'(rl); rd_addr = AW'(rk); layer_clr = clr;

        wlegal = wv && wl >= 1 && wl <= LOG2N && wk >= 0 && wk < n_chunks(1 << wl);
        rlegal = rv && rl >= 1 && rl <= LOG2N && rk >= 0 && rk < n_chunks(1 << (rl - 1));
        ws = wlegal ? (1 << wl) - 2 + wk * P : 0;
        wn = wlegal ? ((1 << wl) < P ? (1 << wl) : P) : 0;
        exp_l = '0; exp_r = '0;
        exp_dv = !rs && rlegal;
        exp_re = !rs && rv && !rlegal;
        exp_we = !rs && wv && !wlegal;
        if (exp_dv) begin
            h  = 1 << (rl - 1);
            rn = (h < P) ? h : P;
            lb = (1 << rl) - 2 + rk * P;
            for (int i = 0; i < rn; i++) begin
                e = lb + i;
                exp_l[i*Q +: Q] = (BYPASS && e >= ws && e < ws + wn) ? wd[(e - ws)*Q +: Q] : Q'(ref_mem[e]);
                e = lb + h + i;
                exp_r[i*Q +: Q] = (BYPASS && e >= ws && e < ws + wn) ? wd[(e - ws)*Q +: Q] : Q'(ref_mem[e]);
            end
        end

        for (int l = 1; l <= LOG2N; l++) begin
            if (rs || clr[l-1]) ref_done[l] = '0;
        end
        if (wlegal && !rs) ref_done[wl][wk] = 1'b1;
        for (int l = 1; l <= LOG2N; l++) begin
            all_done = 1'b1;
            for (int k = 0; k < n_chunks(1 << l); k++) all_done &= ref_done[l][k];
            exp_rdy[l-1] = all_done;
        end
        if (wlegal) begin
            for (int i = 0; i < wn; i++) ref_mem[ws + i] = int'(wd[i*Q +: Q]);
        end

        @(posedge clk);
        #1;
        check_val("rd_left", rd_left, exp_l);
        check_val("rd_right", rd_right, exp_r);
        check_val("rd_data_valid", DW'(rd_data_valid), DW'(exp_dv));
        check_val("rd_err", DW'(rd_err), DW'(exp_re));
        check_val("wr_err", DW'(wr_err), DW'(exp_we));
        check_val("layer_rdy", DW'(layer_rdy), DW'(exp_rdy));
    endtask

    task automatic idle(input bit rs);
        run_cycle(1'b0, 0, 0, '0, 1'b0, 0, 0, '0, rs);
    endtask

    initial begin
        logic [DW-1:0] d;
        int wl, wk, rl, rk, wc, rc;
        n_checks = 0;
        n_errors = 0;
        for (int l = 0; l <= LOG2N; l++) ref_done[l] = '0;
        rst = 1'b1; wr_valid = 1'b0; wr_layer = '0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_layer = '0; rd_addr = '0; layer_clr = '0;

        // Reset with a read request in flight: nothing may come out.
        run_cycle(1'b0, 0, 0, '0, 1'b1, 10, 0, '0, 1'b1);
        run_cycle(1'b0, 0, 0, '0, 1'b1, 10, 1, '0, 1'b1);
        idle(1'b0);

        // Fill layers 1..9 with random data.
        for (int l = 1; l <= 9; l++)
            for (int k = 0; k < n_chunks(1 << l); k++)
                run_cycle(1'b1, l, k, rand_data(), 1'b0, 0, 0, '0, 1'b0);

        // Layer 10 with lane value (k*128+i)&63.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < P; i++) d[i*Q +: Q] = Q'((k * 128 + i) & 63);
            run_cycle(1'b1, 10, k, d, 1'b0, 0, 0, '0, 1'b0);
            if (k == 6) check_val("l10_rdy_after7", DW'(layer_rdy[9]), DW'(1'b0));
        end
        check_val("l10_rdy_after8", DW'(layer_rdy[9]), DW'(1'b1));
        run_cycle(1'b0, 0, 0, '0, 1'b1, 10, 1, '0, 1'b0);
        check_val("l10_left0", DW'(rd_left[0 +: Q]), DW'(6'd0));
        check_val("l10_right0", DW'(rd_right[0 +: Q]), DW'(6'd0));
        check_val("l10_right5", DW'(rd_right[5*Q +: Q]), DW'(6'd5));
        check_val("l10_valid", DW'(rd_data_valid), DW'(1'b1));

        // Small layer: half-layer of 4 lanes, upper lanes zero.
        d = rand_data();
        for (int i = 0; i < 8; i++) d[i*Q +: Q] = Q'(i + 1);
        run_cycle(1'b1, 3, 0, d, 1'b0, 0, 0, '0, 1'b0);
        run_cycle(1'b0, 0, 0, '0, 1'b1, 3, 0, '0, 1'b0);
        check_val("l3_left", DW'(rd_left), DW'({6'd4, 6'd3, 6'd2, 6'd1}));
        check_val("l3_right", DW'(rd_right), DW'({6'd8, 6'd7, 6'd6, 6'd5}));

        // Range errors.
        run_cycle(1'b1, 9, 4, rand_data(), 1'b0, 0, 0, '0, 1'b0);
        check_val("wr_l9_k4_err", DW'(wr_err), DW'(1'b1));
        run_cycle(1'b0, 0, 0, '0, 1'b1, 10, 0, '0, 1'b0);
        run_cycle(1'b0, 0, 0, '0, 1'b1, 10, 4, '0, 1'b0);
        check_val("rd_l10_k4_err", DW'(rd_err), DW'(1'b1));
        run_cycle(1'b0, 0, 0, '0, 1'b1, 0, 0, '0, 1'b0);
        check_val("rd_l0_err", DW'(rd_err), DW'(1'b1));
        run_cycle(1'b1, 0, 0, rand_data(), 1'b1, 11, 0, '0, 1'b0);
        run_cycle(1'b1, 11, 0, rand_data(), 1'b0, 0, 0, '0, 1'b0);
        idle(1'b0);

        // Same-cycle write and read to the same entries.
        d = rand_data();
        d[0 +: Q] = 6'd7;
        run_cycle(1'b1, 8, 0, d, 1'b0, 0, 0, '0, 1'b0);
        d[0 +: Q] = 6'd9;
        run_cycle(1'b1, 8, 0, d, 1'b1, 8, 0, '0, 1'b0);
        check_val("collide_lane0", DW'(rd_left[0 +: Q]), BYPASS ? DW'(6'd9) : DW'(6'd7));

        // Clear of a ready layer, then refill.
        run_cycle(1'b0, 0, 0, '0, 1'b0, 0, 0, 10'h200, 1'b0);
        check_val("clr_l10", DW'(layer_rdy[9]), DW'(1'b0));
        for (int k = 0; k < 8; k++) run_cycle(1'b1, 10, k, rand_data(), 1'b0, 0, 0, '0, 1'b0);
        check_val("refill_l10", DW'(layer_rdy[9]), DW'(1'b1));
        // Clear and write together: single-chunk layer ends ready, multi-chunk layer does not.
        run_cycle(1'b1, 1, 0, rand_data(), 1'b0, 0, 0, 10'h001, 1'b0);
        check_val("clrwr_l1", DW'(layer_rdy[0]), DW'(1'b1));
        run_cycle(1'b1, 9, 0, rand_data(), 1'b0, 0, 0, 10'h100, 1'b0);
        check_val("clrwr_l9", DW'(layer_rdy[8]), DW'(1'b0));

        // Random traffic, including out-of-range layers and chunk indices.
        for (int c = 0; c < 400; c++) begin
            wl = $urandom_range(0, 11);
            wc = (wl >= 1 && wl <= LOG2N) ? n_chunks(1 << wl) : 15;
            wk = $urandom_range(0, wc);
            rl = $urandom_range(0, 11);
            rc = (rl >= 1 && rl <= LOG2N) ? n_chunks(1 << (rl - 1)) : 15;
            rk = $urandom_range(0, rc);
            if ($urandom_range(0, 5) == 0) begin
                rl = wl;
                rk = 0;
            end
            run_cycle($urandom_range(0, 3) != 0, wl, wk, rand_data(),
                      $urandom_range(0, 3) != 0, rl, rk,
                      ($urandom_range(0, 15) == 0) ? LOG2N'($urandom) : '0, 1'b0);
        end

        // Reset in the middle of traffic with a legal read.
        run_cycle(1'b0, 0, 0, '0, 1'b1, 10, 0, '0, 1'b1);
        check_val("midrst_valid", DW'(rd_data_valid), DW'(1'b0));
        check_val("midrst_rdy", DW'(layer_rdy), DW'(10'd0));
        run_cycle(1'b0, 0, 0, '0, 1'b1, 5, 0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alpha_layer_mem.md
Name: alpha_layer_mem

Overview:
- Parametrised LLR (alpha) storage for the SCAN polar decoder. Holds one alpha vector per tree layer; layer l holds 2^l entries of Q bits.
- Chunked P-lane write port and a P-lane read port that returns the left and right halves of a layer.
- Sits between the F/G processing-element array and the layer scheduler.
- Generalises the fixed N=1024 layer store:
  - any power-of-two N and P;
  - one-cycle registered read with a valid strobe;
  - address range checking;
  - per-layer completion tracking.

Parameters:
- Q, 6, LLR width in bits.
- P, 128, processing lanes per access (power of two, P <= N/2).
- N, 1024, code length (power of two, N >= 4).
- Derived, localparam:
  - LOG2N = $clog2(N).
  - LOG2P = $clog2(P).
  - LW = $clog2(LOG2N+1).
  - AW = LOG2N-LOG2P+1.
  - CMAX = N/P.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  1  write request
- wr_layer  in  LW  target layer, 1..LOG2N
- wr_addr  in  AW  chunk index within the layer
- wr_data  in  P*Q  lane i in bits [i*Q+:Q]
- rd_valid  in  1  read request
- rd_layer  in  LW  source layer, 1..LOG2N
- rd_addr  in  AW  chunk index within the half-layer
- layer_clr  in  LOG2N  bit l-1 clears the ready tracking of layer l
- rd_left  out  P*Q  left-half LLRs
- rd_right  out  P*Q  right-half LLRs
- rd_data_valid  out  1  rd_left/rd_right valid this cycle
- wr_err  out  1  one-cycle pulse: write rejected
- rd_err  out  1  one-cycle pulse: read rejected
- layer_rdy  out  LOG2N  bit l-1 set when every chunk of layer l has been written since the last clear

Behaviour:
- Storage layout:
  - Flat array of 2N-2 entries; layer l has base 2^l-2.
  - Contents are not reset; only control state and outputs are reset.
- Write, when wr_valid=1:
  - W = min(P, 2^l) lanes; legal chunks k in 0..max(2^l/P,1)-1.
  - Entries base+k*P+i are written from lane i, for i<W. Lanes i>=W are ignored.
  - Data is stored at the clock edge.
- Illegal write (layer 0, layer > LOG2N, or k out of range):
  - no store;
  - wr_err=1 in the next cycle.
- Read, when rd_valid=1:
  - H = 2^(l-1); R = min(P, H); legal k in 0..max(H/P,1)-1.
  - Next cycle: rd_left lane i = entry base+k*P+i, and rd_right lane i = entry base+H+k*P+i, for i<R.
  - Lanes >= R are zero.
  - rd_data_valid=1.
- Illegal read:
  - next cycle rd_left=rd_right=0, rd_data_valid=0, rd_err=1.
- No read accepted: the next cycle has rd_left=rd_right=0 and rd_data_valid=0.
- Latency: write to memory takes 1 edge; read request to data is exactly 1 cycle. Back-to-back reads are allowed every cycle.
- Same-cycle write and read to overlapping entries: the read returns the pre-write (old) data unless the optional feature below is compiled in.
- Ready tracking:
  - A per-layer chunk-written bitmap of max(2^l/P,1) bits.
  - A legal write sets the chunk bit.
  - layer_rdy[l-1] is registered: it equals the AND of that bitmap, one cycle after the final chunk write.
- layer_clr: clears the layer's bitmap and rdy in the next cycle.
- Same-cycle layer_clr and write to that layer: the clear is applied first, then the write's chunk bit is set. rdy ends as 1 only if that layer has a single chunk.
- Reset values: all outputs 0 and all bitmaps 0.
- Reset mid-read: a read accepted in the rst cycle produces no rd_data_valid.

Optional Feature:
- Macro: ALPHA_MEM_BYPASS_EN.
- Defined: write-to-read forwarding. On a same-cycle legal write and legal read, any read lane whose entry index equals a written entry returns the new wr_data lane.
- Undefined: no forwarding; old data is returned; less logic.

Decomposition:
- Package polar_mem_pkg:
  - function layer_base(l) = 2^l-2;
  - function layer_chunks(l, P);
  - LLR width constant Q_DEF=6;
  - typedef llr_t = logic [Q-1:0].
- Sub-module alpha_chunk_tracker:
  - per-layer bitmaps;
  - layer_clr handling;
  - layer_rdy generation.
- Memory and read datapath stay in the top.

Test Plan:
- Defaults used throughout (N=1024, P=128, Q=6).
- Layer 10 fill: write chunks k=0..7, lane i = (k*128+i)&63 -> layer_rdy[9]=0 after 7 writes, =1 one cycle after the 8th. rd layer 10, k=1 -> next cycle left lane 0=128&63=0, right lane 0=(512+128)&63=0, lane 5=5; rd_data_valid=1.
- Small layer: write layer 3 with lanes 0..7 = 1..8, then read k=0 -> left lanes 0..3 = 1,2,3,4; right lanes 0..3 = 5,6,7,8; lanes 4..127 = 0.
- Range errors:
  - wr layer 9, k=4 -> wr_err pulse, memory unchanged;
  - rd layer 10, k=4 -> rd_err=1, rd_data_valid=0, outputs 0;
  - rd layer 0 -> rd_err=1.
- Collision: preload layer 8 k=0 with lane 0 = 7. Same cycle: write layer 8 k=0 lane 0 = 9, and read layer 8 k=0 -> rd_left lane 0 = 7 without ALPHA_MEM_BYPASS_EN, 9 with it.
- Clear/reset:
  - layer_clr[9] pulse while layer 10 is ready -> layer_rdy[9]=0 next cycle; a rewrite of all 8 chunks re-asserts it.
  - rst asserted the same cycle as a rd_valid -> no rd_data_valid; all outputs 0.
